// File: rtl/ppf_pkg.sv
// Shared types, sizes and prototype coefficients for the 8-branch polyphase filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ppf_pkg;

  localparam int DATA_W     = 32;
  localparam int COEF_W     = 16;
  localparam int OUT_W      = 64;
  localparam int TAPS       = 4;
  localparam int NUM_BRANCH = 8;
  localparam int PROTO_LEN  = NUM_BRANCH * TAPS;
  localparam int PROTO_AW   = $clog2(PROTO_LEN);
  localparam int PROD_W     = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [OUT_W-1:0]  acc_t;

  // Hamming-windowed sinc, cutoff pi/8, centre between taps 15 and 16,
  // scaled so a unit sinc peak maps to 16384.
  localparam coef_t PPF_PROTO [0:PROTO_LEN-1] = '{
    -16'sd42,   -16'sd143,  -16'sd301,  -16'sd532,
    -16'sd794,  -16'sd980,  -16'sd928,  -16'sd450,
     16'sd611,   16'sd2337,  16'sd4684,  16'sd7471,
     16'sd10389, 16'sd13056, 16'sd15127, 16'sd16241,
     16'sd16241, 16'sd15127, 16'sd13056, 16'sd10389,
     16'sd7471,  16'sd4684,  16'sd2337,  16'sd611,
    -16'sd450,  -16'sd928,  -16'sd980,  -16'sd794,
    -16'sd532,  -16'sd301,  -16'sd143,  -16'sd42
  };

  // Tap j of branch k is every 8th prototype coefficient starting at k.
  function automatic coef_t get_coef(input int k, input int j);
    logic [PROTO_AW-1:0] idx;
    idx = PROTO_AW'(k + NUM_BRANCH * j);
    return PPF_PROTO[idx];
  endfunction

endpackage

// File: rtl/ppf_branch.sv
// One polyphase branch: fixed-coefficient 4-tap FIR over a single channel.
// Latency: 1 cycle from accepted sample to registered output.
// Backpressure: none; every cycle with valid_i=1 is consumed, outputs hold otherwise.
// Ports: clk_i/rstn_i clock and async active-low reset; valid_i sample strobe;
//        data_i signed input sample; data_o signed 64-bit filtered output.
module ppf_branch
  import ppf_pkg::*;
#(
  parameter int BRANCH_IDX = 0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [OUT_W-1:0]  data_o
);

  // Only TAPS-1 samples of history are stored: the oldest tap reads the
  // pre-shift last stage directly, and the sample shifted out is never used.
  sample_t                    r_dly [TAPS-1];
  acc_t                       r_out;
  sample_t                    w_x   [TAPS];
  logic signed [PROD_W-1:0]   w_prod[TAPS];
  acc_t                       w_sum;

  always_comb begin
    w_x[0] = data_i;
    for (int j = 1; j < TAPS; j++) begin
      w_x[j] = r_dly[j-1];
    end
  end

  // 48-bit exact products summed at full output width: the 50-bit true sum
  // always fits, so no rounding or saturation is needed.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < TAPS; j++) begin
      w_prod[j] = PROD_W'(w_x[j]) * PROD_W'(get_coef(BRANCH_IDX, j));
      w_sum     = w_sum + OUT_W'(w_prod[j]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int j = 0; j < TAPS-1; j++) begin
        r_dly[j] <= '0;
      end
      r_out <= '0;
    end else if (valid_i) begin
      r_dly[0] <= data_i;
      for (int j = 1; j < TAPS-1; j++) begin
        r_dly[j] <= r_dly[j-1];
      end
      r_out <= w_sum;
    end
  end

  assign data_o = r_out;

endmodule

// File: rtl/ppf_top.sv
// Polyphase filter front end: 8 independent FIR branches sharing one valid strobe.
// Latency: 1 cycle from data_valid_i edge to channelk_data_o.
// Backpressure: none; no ready, outputs simply hold between valid cycles.
// Ports: clk_i, rstn_i (async active-low); data_valid_i; channel0..7_data_i
//        32-bit signed samples; channel0..7_data_o 64-bit signed branch outputs.
module ppf_top
  import ppf_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     data_valid_i,
  input  logic signed [DATA_W-1:0] channel0_data_i,
  input  logic signed [DATA_W-1:0] channel1_data_i,
  input  logic signed [DATA_W-1:0] channel2_data_i,
  input  logic signed [DATA_W-1:0] channel3_data_i,
  input  logic signed [DATA_W-1:0] channel4_data_i,
  input  logic signed [DATA_W-1:0] channel5_data_i,
  input  logic signed [DATA_W-1:0] channel6_data_i,
  input  logic signed [DATA_W-1:0] channel7_data_i,
  output logic signed [OUT_W-1:0]  channel0_data_o,
  output logic signed [OUT_W-1:0]  channel1_data_o,
  output logic signed [OUT_W-1:0]  channel2_data_o,
  output logic signed [OUT_W-1:0]  channel3_data_o,
  output logic signed [OUT_W-1:0]  channel4_data_o,
  output logic signed [OUT_W-1:0]  channel5_data_o,
  output logic signed [OUT_W-1:0]  channel6_data_o,
  output logic signed [OUT_W-1:0]  channel7_data_o
);

  sample_t w_din  [NUM_BRANCH];
  acc_t    w_dout [NUM_BRANCH];

  assign w_din[0] = channel0_data_i;
  assign w_din[1] = channel1_data_i;
  assign w_din[2] = channel2_data_i;
  assign w_din[3] = channel3_data_i;
  assign w_din[4] = channel4_data_i;
  assign w_din[5] = channel5_data_i;
  assign w_din[6] = channel6_data_i;
  assign w_din[7] = channel7_data_i;

  assign channel0_data_o = w_dout[0];
  assign channel1_data_o = w_dout[1];
  assign channel2_data_o = w_dout[2];
  assign channel3_data_o = w_dout[3];
  assign channel4_data_o = w_dout[4];
  assign channel5_data_o = w_dout[5];
  assign channel6_data_o = w_dout[6];
  assign channel7_data_o = w_dout[7];

  for (genvar g = 0; g < NUM_BRANCH; g++) begin : g_branch
    ppf_branch #(
      .BRANCH_IDX (g)
    ) u_branch (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (data_valid_i),
      .data_i  (w_din[g]),
      .data_o  (w_dout[g])
    );
  end

endmodule

// File: tb/tb_ppf_top.sv
module tb_ppf_top;

  typedef logic signed [7:0][63:0] exp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        data_valid_i;
  logic [31:0] din  [8];
  logic [31:0] nxt  [8];
  logic [63:0] dout [8];

  int checks = 0;
  int errors = 0;

  // Independent copy of the prototype filter.
  int H [32] = '{
      -42,  -143,  -301,  -532,  -794,  -980,  -928,  -450,
      611,  2337,  4684,  7471, 10389, 13056, 15127, 16241,
    16241, 15127, 13056, 10389,  7471,  4684,  2337,   611,
     -450,  -928,  -980,  -794,  -532,  -301,  -143,   -42
  };

  longint hist     [8][3];
  longint last_out [8];
  exp_t   sb_q [$];

  always #5 clk_i = ~clk_i;

  ppf_top dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .data_valid_i    (data_valid_i),
    .channel0_data_i (din[0]),
    .channel1_data_i (din[1]),
    .channel2_data_i (din[2]),
    .channel3_data_i (din[3]),
    .channel4_data_i (din[4]),
    .channel5_data_i (din[5]),
    .channel6_data_i (din[6]),
    .channel7_data_i (din[7]),
    .channel0_data_o (dout[0]),
    .channel1_data_o (dout[1]),
    .channel2_data_o (dout[2]),
    .channel3_data_o (dout[3]),
    .channel4_data_o (dout[4]),
    .channel5_data_o (dout[5]),
    .channel6_data_o (dout[6]),
    .channel7_data_o (dout[7])
  );

  task automatic check_val(input string tag, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic longint colsum(input int k);
    return longint'(H[k] + H[k+8] + H[k+16] + H[k+24]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      last_out[k] = 0;
      for (int j = 0; j < 3; j++) hist[k][j] = 0;
    end
    sb_q.delete();
  endtask

  // Drive one cycle at the falling edge, predict on valid, compare 1 ns after
  // the rising edge (scoreboard entry if one was pushed, else held value).
  task automatic step_cycle(input logic vld);
    exp_t   e;
    longint x;
    @(negedge clk_i);
    data_valid_i = vld;
    for (int k = 0; k < 8; k++) din[k] = nxt[k];
    if (vld && rstn_i) begin
      for (int k = 0; k < 8; k++) begin
        x = longint'($signed(nxt[k]));
        e[k] = x * H[k] + hist[k][0] * H[k+8] + hist[k][1] * H[k+16]
             + hist[k][2] * H[k+24];
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = x;
        last_out[k] = e[k];
      end
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int k = 0; k < 8; k++) check_val($sformatf("out%0d", k), dout[k], e[k]);
    end else begin
      for (int k = 0; k < 8; k++) check_val($sformatf("hold%0d", k), dout[k], last_out[k]);
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < 8; k++) nxt[k] = v;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 8; k++) nxt[k] = $urandom;
  endtask

  // Assumes zero history on entry.
  task automatic run_impulse(input string name);
    for (int j = 0; j < 5; j++) begin
      set_all((j == 0) ? 32'd1 : 32'd0);
      step_cycle(1'b1);
      for (int k = 0; k < 8; k++)
        check_val($sformatf("%s_ch%0d_t%0d", name, k, j), dout[k],
                  (j < 4) ? longint'(H[k + 8*j]) : 64'sd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rstn_i       = 1'b0;
    data_valid_i = 1'b0;
    set_all(32'd0);
    for (int k = 0; k < 8; k++) din[k] = '0;
    model_reset();

    // Reset held 200 ns with live random traffic: outputs must stay zero.
    for (int i = 0; i < 20; i++) begin
      set_rand();
      step_cycle(1'b1);
    end
    rstn_i = 1'b1;
    // First valid after release sees only the current sample.
    set_rand();
    step_cycle(1'b1);
    // Flush history to zero, then impulse on all channels.
    set_all(32'd0);
    for (int i = 0; i < 3; i++) step_cycle(1'b1);
    run_impulse("imp");

    // Step response.
    set_all(32'd1000);
    for (int i = 0; i < 16; i++) step_cycle(1'b1);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("step_ch%0d", k), dout[k], 1000 * colsum(k));

    // Same step data with idle gaps; outputs hold through idles.
    set_all(32'd0);
    for (int i = 0; i < 4; i++) step_cycle(1'b1);
    set_all(32'd1000);
    for (int i = 0; i < 16; i++) begin
      step_cycle(1'b1);
      repeat ($urandom_range(1, 3)) step_cycle(1'b0);
    end
    for (int k = 0; k < 8; k++)
      check_val($sformatf("gap_ch%0d", k), dout[k], 1000 * colsum(k));

    // Extreme inputs.
    set_all(32'd0);
    nxt[0] = 32'h8000_0000;
    nxt[1] = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) step_cycle(1'b1);
    check_val("ext_min", dout[0], -(longint'(1) <<< 31) * colsum(0));
    check_val("ext_max", dout[1], ((longint'(1) <<< 31) - 1) * colsum(1));

    // Mid-stream asynchronous reset between edges.
    for (int i = 0; i < 8; i++) begin
      set_rand();
      step_cycle(1'b1);
    end
    @(posedge clk_i);
    #3;
    rstn_i = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) check_val($sformatf("arst_ch%0d", k), dout[k], 64'sd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      set_rand();
      step_cycle(1'b1);
    end
    rstn_i = 1'b1;
    run_impulse("imp2");

    data_valid_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppf_top.md
Name: ppf_top

Overview:
- Direct-form polyphase filter (PPF) front end: 8 parallel branches, one per input channel; each branch is a fixed-coefficient FIR running on its own sample stream.
- Branch k applies taps h[k+8j], j=0..3, taken from a 32-tap prototype low-pass filter h[n].
- Sits between the channel de-interleaver (upstream) and the FFT/DFT stage (downstream); no FFT is done here.
- All 8 branches advance together on one shared valid strobe.

Parameters:
- DATA_W, 32, signed input sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 64, signed output width.
- TAPS, 4, taps per branch (prototype length = 8*TAPS).
- Branch count is fixed at 8 by the port list.

Ports:
- clk_i  in  1  system clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- data_valid_i  in  1  a new sample is present on all 8 channel inputs this cycle.
- channel0_data_i .. channel7_data_i  in  32 each  signed samples; channel k feeds branch k.
- channel0_data_o .. channel7_data_o  out  64 each  signed filtered output of branch k.
- No output valid port.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rstn_i is asynchronous and active-low.
- While rstn_i=0: every delay-line register and every output register clears to 0 immediately, with no clock edge needed.
- Per-branch delay line d0..d3, where d0 is the newest sample.
- On a rising edge with data_valid_i=1:
  - Shift d3<=d2, d2<=d1, d1<=d0, d0<=channelk_data_i.
  - Register out_k <= sum over j of C[k][j]*x_j, where x_0 = the incoming sample and x_j = the pre-shift d(j-1) for j>=1.
  - Latency: the output reflects the sample presented at edge N immediately after edge N (1 cycle).
- data_valid_i=0: delay lines and outputs hold their values. Gaps of any length are allowed; valid may stay high continuously.
- Arithmetic:
  - Each product is 32x16 signed, giving 48 bits.
  - The sum of 4 products is 50 bits. It is sign-extended to 64 bits, so no overflow or saturation is possible.
  - No rounding or truncation.
- Coefficients are constants, C[k][j] = h[k+8j], signed 16-bit two's complement.
- Extreme inputs (0x80000000, 0x7FFFFFFF) must produce exact results.
- Reset asserted mid-stream clears all history. The first valid after release behaves as if all prior samples were 0.
- Branches are fully independent: no cross-channel mixing.

Decomposition:
- Package ppf_pkg holds:
  - DATA_W, COEF_W, OUT_W, TAPS, NUM_BRANCH=8.
  - Typedefs sample_t (logic signed [31:0]), coef_t (signed [15:0]), acc_t (signed [63:0]).
  - Constant array PPF_PROTO[0:31] of coef_t; the default is a windowed-sinc low-pass with cutoff pi/8.
  - Function get_coef(k,j) returning PPF_PROTO[k+8*j].
- Sub-module ppf_branch:
  - Parameter BRANCH_IDX; ports clk_i, rstn_i, valid_i, data_i, data_o.
  - Instantiated 8 times via generate in ppf_top.

Test Plan:
- Reset: hold rstn_i=0 for 200 ns and drive random inputs with valid=1. All 8 outputs = 0 throughout; after release, first output = C[k][0]*x only.
- Impulse: channel k = 1 for one valid cycle, then 0 for 3 valid cycles. channelk_data_o sequence is h[k], h[k+8], h[k+16], h[k+24], then 0. Repeat for all 8 channels simultaneously.
- Step: all channels = 1000 on 16 consecutive valids. From the 4th valid on, out_k = 1000*sum_j h[k+8j] and holds constant.
- Valid gaps: interleave valid with 1-3 idle cycles, using the same data as the step test. Outputs hold during idles; the final values match the step test.
- Extremes: channel0 = 0x80000000, channel1 = 0x7FFFFFFF, held for 4 valids. Outputs equal exact 64-bit sums, matching a reference model bit-for-bit.
- Mid-stream reset: assert rstn_i asynchronously between edges after 8 samples. Outputs are 0 immediately; after release, the impulse test passes unchanged.
